// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: LFSR pattern source, synchronous core clear, MISR compaction and golden compare.
// Optional serial signature read-out in DONE is enabled by defining BIST_SIG_SHIFT_EN.
module bist_seq_ctrl #(
    parameter int              IN_W      = 18,
    parameter int              OUT_W     = 19,
    parameter int              NPAT      = 256,
    parameter int              CLR_CYC   = 1,
    parameter logic [IN_W-1:0] TPG_POLY  = IN_W'(1) | (IN_W'(1) << (IN_W - 1)),
    parameter logic [IN_W-1:0] TPG_SEED  = IN_W'(1),
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(3)
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    input  logic [OUT_W-1:0] CUT_OUT,
    input  logic [OUT_W-1:0] GOLDEN,
`ifdef BIST_SIG_SHIFT_EN
    input  logic             SHIFT,
    output logic             SO,
`endif
    output logic [IN_W-1:0]  CUT_IN,
    output logic             CUT_CLR,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [OUT_W-1:0] SIG
);

    // cnt serves both INIT and RUN, so it is sized for the longer of the two
    localparam int CNT_MAX = (NPAT > CLR_CYC) ? NPAT : CLR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IN_W-1:0] SEED_C = (TPG_SEED == {IN_W{1'b0}}) ? IN_W'(1) : TPG_SEED;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_CMP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [IN_W-1:0]    lfsr_r, lfsr_s, cut_in_r;
    logic [OUT_W-1:0]   sig_r, sig_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               pass_r, pass_s;
    logic               cut_clr_r, busy_r, done_r;
    logic               shift_s;

    function automatic logic parity_f(input logic [IN_W-1:0] v);
        return ^v;
    endfunction

    function automatic logic [OUT_W-1:0] misr_next_f(input logic [OUT_W-1:0] s,
                                                     input logic [OUT_W-1:0] d);
        return {s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}}) ^ d;
    endfunction

`ifdef BIST_SIG_SHIFT_EN
    assign shift_s = SHIFT;
    assign SO      = sig_r[OUT_W-1];
`else
    assign shift_s = 1'b0;
`endif

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_s = state_r;
        lfsr_s  = lfsr_r;
        sig_s   = sig_r;
        cnt_s   = cnt_r;
        pass_s  = pass_r;
        case (state_r)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    state_s = ST_INIT;
                    lfsr_s  = SEED_C;
                    sig_s   = {OUT_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    pass_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (ABORT) begin
                    state_s = ST_IDLE;
                    pass_s  = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_W'(CLR_CYC - 1)) begin
                    state_s = ST_RUN;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // an aborted run keeps the partial signature untouched
                if (ABORT) begin
                    state_s = ST_IDLE;
                    pass_s  = 1'b0;
                end else begin
                    lfsr_s = {lfsr_r[IN_W-2:0], parity_f(lfsr_r & TPG_POLY)};
                    sig_s  = misr_next_f(sig_r, CUT_OUT);
                    cnt_s  = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(NPAT - 1)) begin
                        state_s = ST_CMP;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_CMP: begin
                if (ABORT) begin
                    state_s = ST_IDLE;
                    pass_s  = 1'b0;
                end else begin
                    state_s = ST_DONE;
                    pass_s  = (sig_r == GOLDEN);
                end
            end
            ST_DONE: begin
                if (!START) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
                if (shift_s) begin
                    sig_s = {sig_r[OUT_W-2:0], 1'b0};
                end else begin
                    sig_s = sig_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs decode the next state so they align with it
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_r   <= ST_IDLE;
            lfsr_r    <= {IN_W{1'b0}};
            sig_r     <= {OUT_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            pass_r    <= 1'b0;
            cut_in_r  <= {IN_W{1'b0}};
            cut_clr_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            lfsr_r    <= lfsr_s;
            sig_r     <= sig_s;
            cnt_r     <= cnt_s;
            pass_r    <= pass_s;
            cut_in_r  <= (state_s == ST_RUN) ? lfsr_s : {IN_W{1'b0}};
            cut_clr_r <= (state_s == ST_INIT);
            busy_r    <= (state_s == ST_INIT) || (state_s == ST_RUN) || (state_s == ST_CMP);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign CUT_IN  = cut_in_r;
    assign CUT_CLR = cut_clr_r;
    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign PASS    = pass_r;
    assign SIG     = sig_r;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Scoreboard bench for bist_seq_ctrl: per-edge stimulus and expected outputs are queued, then replayed.
// Exercises the BIST_SIG_SHIFT_EN read-out when that macro is defined.
module tb_bist_seq_ctrl;

    localparam int CLR = 2;
    localparam int NP  = 6;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [3:0] CUT_OUT = 4'd0;
    logic [3:0] GOLDEN = 4'd0;
    logic [3:0] CUT_IN;
    logic       CUT_CLR, BUSY, DONE, PASS;
    logic [3:0] SIG;
`ifdef BIST_SIG_SHIFT_EN
    logic       SHIFT = 1'b0;
    logic       SO;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       rn;
        logic       start;
        logic       abort;
        logic [3:0] co;
        logic [3:0] gold;
    } stim_t;

    stim_t      stim_q[$];
    logic [11:0] exp_q[$];

    bist_seq_ctrl #(
        .IN_W(4), .OUT_W(4), .NPAT(NP), .CLR_CYC(CLR),
        .TPG_POLY(4'b1001), .TPG_SEED(4'b0001), .MISR_POLY(4'b0011)
    ) dut (
        .CK(CK), .RN(RN), .START(START), .ABORT(ABORT),
        .CUT_OUT(CUT_OUT), .GOLDEN(GOLDEN),
`ifdef BIST_SIG_SHIFT_EN
        .SHIFT(SHIFT), .SO(SO),
`endif
        .CUT_IN(CUT_IN), .CUT_CLR(CUT_CLR), .BUSY(BUSY), .DONE(DONE),
        .PASS(PASS), .SIG(SIG)
    );

    always #5 CK = ~CK;

    function automatic logic [3:0] lfsr_m(input logic [3:0] v);
        return {v[2:0], v[3] ^ v[0]};
    endfunction

    function automatic logic [3:0] misr_m(input logic [3:0] s, input logic [3:0] d);
        return {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000) ^ d;
    endfunction

    // Queue one scenario: edge e is driven with stim e, outputs after edge e must equal exp e.
    task automatic build_run(input bit want_pass, input bit const_co, input int abort_e,
                             input int rst_e, input int rel_e, input int n_e);
        logic [3:0] lf, sg, co, gd;
        logic       ps;
        int         t, base;
        bit         aborted;
        stim_t      s;
        logic [11:0] x;
        lf = 4'd0; sg = 4'd0; ps = 1'b0; base = 0; aborted = 1'b0;
        for (int e = 0; e < n_e; e++) begin
            co = const_co ? 4'b0001 : 4'($urandom);
            gd = 4'($urandom);
            t  = e - base;
            if (e == rst_e) begin
                lf = 4'd0; sg = 4'd0; ps = 1'b0; base = e + 1;
                x  = 12'd0;
            end else if (aborted || e == abort_e) begin
                aborted = 1'b1; ps = 1'b0;
                x = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, sg};
            end else begin
                if (t == 0) begin
                    lf = 4'b0001; sg = 4'd0; ps = 1'b0;
                end else if (t - 1 >= CLR && t - 1 < CLR + NP) begin
                    sg = misr_m(sg, co); lf = lfsr_m(lf);
                end else if (t - 1 == CLR + NP) begin
                    gd = want_pass ? sg : (sg ^ 4'b0110);
                    ps = (gd == sg);
                end
                if (t < CLR)            x = {4'd0, 1'b1, 1'b1, 1'b0, ps, sg};
                else if (t < CLR + NP)  x = {lf,   1'b0, 1'b1, 1'b0, ps, sg};
                else if (t == CLR + NP) x = {4'd0, 1'b0, 1'b1, 1'b0, ps, sg};
                else if (e < rel_e)     x = {4'd0, 1'b0, 1'b0, 1'b1, ps, sg};
                else                    x = {4'd0, 1'b0, 1'b0, 1'b0, ps, sg};
            end
            s.rn    = (e != rst_e);
            s.start = (e < rel_e) && (abort_e < 0 || e < abort_e);
            s.abort = (e == abort_e);
            s.co    = co;
            s.gold  = gd;
            stim_q.push_back(s);
            exp_q.push_back(x);
        end
    endtask

    task automatic test_reset();
        RN = 1'b0; START = 1'b1; ABORT = 1'b0;
        repeat (3) @(negedge CK);
        n_chk += 6;
        if (CUT_IN !== 4'd0)  begin n_fail++; $display("FAIL reset_cut_in got %h expected 0", CUT_IN); end
        if (CUT_CLR !== 1'b0) begin n_fail++; $display("FAIL reset_cut_clr got %b expected 0", CUT_CLR); end
        if (BUSY !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b expected 0", BUSY); end
        if (DONE !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b expected 0", DONE); end
        if (PASS !== 1'b0)    begin n_fail++; $display("FAIL reset_pass got %b expected 0", PASS); end
        if (SIG !== 4'd0)     begin n_fail++; $display("FAIL reset_sig got %h expected 0", SIG); end
        RN = 1'b1; ABORT = 1'b1;
        repeat (2) @(negedge CK);
        n_chk++;
        if ({BUSY, CUT_CLR} !== 2'b00) begin
            n_fail++; $display("FAIL abort_beats_start got busy/clr %b expected 00", {BUSY, CUT_CLR});
        end
        START = 1'b0; ABORT = 1'b0;
        @(negedge CK);
    endtask

    task automatic test_pass();
        logic [3:0] lfsr_tab [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101};
        logic [3:0] sig_tab  [7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1100, 4'b1010};
        stim_t s; logic [11:0] x; int busy_n, clr_n, e;
        busy_n = 0; clr_n = 0; e = 0;
        build_run(1'b1, 1'b1, -1, -1, 13, 15);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            RN = s.rn; START = s.start; ABORT = s.abort; CUT_OUT = s.co; GOLDEN = s.gold;
            @(negedge CK);
            x = exp_q.pop_front();
            n_chk++;
            if ({CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG} !== x) begin
                n_fail++;
                $display("FAIL pass_run cyc %0d got %h expected %h", e, {CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG}, x);
            end
            if (e >= CLR && e < CLR + NP) begin
                n_chk++;
                if (CUT_IN !== lfsr_tab[e-CLR] || SIG !== sig_tab[e-CLR]) begin
                    n_fail++;
                    $display("FAIL lfsr_misr_table cyc %0d got %h/%h expected %h/%h", e, CUT_IN, SIG, lfsr_tab[e-CLR], sig_tab[e-CLR]);
                end
            end
            if (e == CLR + NP + 1) begin
                n_chk++;
                if ({DONE, PASS, SIG} !== {1'b1, 1'b1, sig_tab[6]}) begin
                    n_fail++; $display("FAIL done_latency got %b expected 111010", {DONE, PASS, SIG});
                end
            end
            busy_n += BUSY; clr_n += CUT_CLR;
            e++;
        end
        n_chk++;
        if (busy_n != CLR + NP + 1 || clr_n != CLR) begin
            n_fail++; $display("FAIL busy_clr_len got %0d/%0d expected %0d/%0d", busy_n, clr_n, CLR + NP + 1, CLR);
        end
    endtask

    task automatic test_fail();
        stim_t s; logic [11:0] x; int e;
        e = 0;
        build_run(1'b0, 1'b0, -1, -1, 12, 13);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            RN = s.rn; START = s.start; ABORT = s.abort; CUT_OUT = s.co; GOLDEN = s.gold;
            @(negedge CK);
            x = exp_q.pop_front();
            n_chk++;
            if ({CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG} !== x) begin
                n_fail++;
                $display("FAIL fail_run cyc %0d got %h expected %h", e, {CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG}, x);
            end
            e++;
        end
    endtask

    task automatic test_abort();
        stim_t s; logic [11:0] x; int e;
        e = 0;
        build_run(1'b1, 1'b0, 5, -1, 99, 9);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            RN = s.rn; START = s.start; ABORT = s.abort; CUT_OUT = s.co; GOLDEN = s.gold;
            @(negedge CK);
            x = exp_q.pop_front();
            n_chk++;
            if ({CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG} !== x) begin
                n_fail++;
                $display("FAIL abort_run cyc %0d got %h expected %h", e, {CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG}, x);
            end
            e++;
        end
    endtask

    task automatic test_reset_mid_run();
        stim_t s; logic [11:0] x; int e;
        e = 0;
        build_run(1'b1, 1'b0, 11, 6, 99, 14);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            RN = s.rn; START = s.start; ABORT = s.abort; CUT_OUT = s.co; GOLDEN = s.gold;
            @(negedge CK);
            x = exp_q.pop_front();
            n_chk++;
            if ({CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG} !== x) begin
                n_fail++;
                $display("FAIL reset_mid_run cyc %0d got %h expected %h", e, {CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG}, x);
            end
            e++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; logic [11:0] x; int e;
        e = 0;
        build_run(1'b1, 1'b0, -1, -1, 11, 12);
        build_run(1'b0, 1'b0, -1, -1, 11, 12);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            RN = s.rn; START = s.start; ABORT = s.abort; CUT_OUT = s.co; GOLDEN = s.gold;
            @(negedge CK);
            x = exp_q.pop_front();
            n_chk++;
            if ({CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG} !== x) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d got %h expected %h", e, {CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG}, x);
            end
            e++;
        end
    endtask

`ifdef BIST_SIG_SHIFT_EN
    task automatic test_sig_shift();
        stim_t s; logic [11:0] x; logic [3:0] m; int e;
        e = 0;
        build_run(1'b1, 1'b1, -1, -1, 99, 11);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            RN = s.rn; START = s.start; ABORT = s.abort; CUT_OUT = s.co; GOLDEN = s.gold;
            @(negedge CK);
            x = exp_q.pop_front();
            n_chk++;
            if ({CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG} !== x) begin
                n_fail++;
                $display("FAIL shift_setup cyc %0d got %h expected %h", e, {CUT_IN, CUT_CLR, BUSY, DONE, PASS, SIG}, x);
            end
            e++;
        end
        m = 4'b1010;
        SHIFT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (SO !== m[3]) begin n_fail++; $display("FAIL shift_so bit %0d got %b expected %b", i, SO, m[3]); end
            @(negedge CK);
            m = {m[2:0], 1'b0};
        end
        n_chk++;
        if ({DONE, PASS, SIG} !== 6'b110000) begin
            n_fail++; $display("FAIL shift_end got %b expected 110000", {DONE, PASS, SIG});
        end
        SHIFT = 1'b0; START = 1'b0;
        @(negedge CK);
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
`ifdef BIST_SIG_SHIFT_EN
        test_sig_shift();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
